// File: rtl/traffic_monitor.sv
// Passive checker for the two-way traffic light lamp buses: phase decode, order and duration checks.
// Optional build macro TRAFFIC_MON_OVERRUN_EN flags a phase as soon as it outlives its tick budget.
module traffic_monitor #(
    parameter int unsigned P1_TICKS = 19,
    parameter int unsigned P2_TICKS = 3,
    parameter int unsigned P3_TICKS = 29,
    parameter int unsigned P4_TICKS = 3
) (
    input  logic        clk100M,
    input  logic        rst,
    input  logic        tick,
    input  logic [2:0]  led1,
    input  logic [2:0]  led2,
    input  logic        err_clr,
    output logic [1:0]  phase,
    output logic        synced,
    output logic [5:0]  tick_cnt,
    output logic [15:0] cycle_cnt,
    output logic        err_illegal,
    output logic        err_order,
    output logic        err_time
);

    localparam logic [5:0] LP_P1     = 6'(P1_TICKS);
    localparam logic [5:0] LP_P2     = 6'(P2_TICKS);
    localparam logic [5:0] LP_P3     = 6'(P3_TICKS);
    localparam logic [5:0] LP_P4     = 6'(P4_TICKS);
    localparam logic [5:0] LP_CNTMAX = 6'd63;

    typedef enum logic [1:0] {
        ST_UNSYNC,
        ST_ARMED,
        ST_TRACK
    } state_t;

    state_t      r_state;
    logic [2:0]  r_led1_q;
    logic [2:0]  r_led2_q;
    logic        r_led_vld;
    logic [1:0]  r_phase;
    logic        r_synced;
    logic [5:0]  r_tick_cnt;
    logic [15:0] r_cycle_cnt;
    logic        r_err_illegal;
    logic        r_err_order;
    logic        r_err_time;

    logic        w_legal;
    logic [1:0]  w_dec;
    logic        w_seen_legal;
    logic        w_change;
    logic        w_succ;
    logic [5:0]  w_target;
    logic        w_ev_ill;
    logic        w_ev_ord;
    logic        w_ev_exit;
    logic        w_ev_over;
    logic        w_over_seen;
    logic        w_ev_time;

    always_comb begin
        w_legal = 1'b1;
        w_dec   = 2'd0;
        case ({r_led1_q, r_led2_q})
            6'b100_001: w_dec = 2'd0;
            6'b100_010: w_dec = 2'd1;
            6'b001_100: w_dec = 2'd2;
            6'b010_100: w_dec = 2'd3;
            default:    w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_target = LP_P1;
        case (r_phase)
            2'd0: w_target = LP_P1;
            2'd1: w_target = LP_P2;
            2'd2: w_target = LP_P3;
            2'd3: w_target = LP_P4;
            default: w_target = LP_P1;
        endcase
    end

    // led_q resets to all-zero, which decodes as illegal; r_led_vld keeps that
    // reset value from being reported before a real bus sample has been taken.
    assign w_seen_legal = r_led_vld && w_legal;
    assign w_ev_ill     = r_led_vld && !w_legal;
    assign w_change     = w_seen_legal && (w_dec != r_phase);
    assign w_succ       = (w_dec == r_phase + 2'd1);
    assign w_ev_ord     = w_change && !w_succ && (r_state != ST_UNSYNC);
    assign w_ev_exit    = (r_state == ST_TRACK) && w_change && w_succ &&
                          (r_tick_cnt != w_target) && !w_over_seen;
    assign w_ev_time    = w_ev_exit || w_ev_over;

`ifdef TRAFFIC_MON_OVERRUN_EN
    logic r_overrun;

    assign w_ev_over   = (r_state == ST_TRACK) && tick && !w_change && !w_ev_ill &&
                         (r_tick_cnt == w_target) && !r_overrun;
    assign w_over_seen = r_overrun;

    always_ff @(posedge clk100M) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_change || w_ev_ill) begin
            r_overrun <= 1'b0;
        end else if (w_ev_over) begin
            r_overrun <= 1'b1;
        end
    end
`else
    assign w_ev_over   = 1'b0;
    assign w_over_seen = 1'b0;
`endif

    always_ff @(posedge clk100M) begin
        if (rst) begin
            r_state       <= ST_UNSYNC;
            r_led1_q      <= '0;
            r_led2_q      <= '0;
            r_led_vld     <= 1'b0;
            r_phase       <= '0;
            r_synced      <= 1'b0;
            r_tick_cnt    <= '0;
            r_cycle_cnt   <= '0;
            r_err_illegal <= 1'b0;
            r_err_order   <= 1'b0;
            r_err_time    <= 1'b0;
        end else begin
            r_led1_q  <= led1;
            r_led2_q  <= led2;
            r_led_vld <= 1'b1;

            r_err_illegal <= (r_err_illegal && !err_clr) || w_ev_ill;
            r_err_order   <= (r_err_order   && !err_clr) || w_ev_ord;
            r_err_time    <= (r_err_time    && !err_clr) || w_ev_time;

            if (w_change) begin
                r_tick_cnt <= tick ? 6'd1 : 6'd0;
            end else if (tick && !w_ev_ill && (r_tick_cnt != LP_CNTMAX)) begin
                r_tick_cnt <= r_tick_cnt + 6'd1;
            end

            if (w_ev_ill) begin
                r_state  <= ST_UNSYNC;
                r_synced <= 1'b0;
            end else if (w_seen_legal) begin
                case (r_state)
                    ST_UNSYNC: begin
                        r_phase <= w_dec;
                        r_state <= ST_ARMED;
                    end
                    ST_ARMED: begin
                        if (w_change) begin
                            r_phase <= w_dec;
                            if (w_succ) begin
                                r_state  <= ST_TRACK;
                                r_synced <= 1'b1;
                            end
                        end
                    end
                    ST_TRACK: begin
                        if (w_change) begin
                            r_phase <= w_dec;
                            if (w_succ) begin
                                if (r_phase == 2'd3) begin
                                    r_cycle_cnt <= r_cycle_cnt + 16'd1;
                                end
                            end else begin
                                r_state  <= ST_ARMED;
                                r_synced <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        r_state  <= ST_UNSYNC;
                        r_synced <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign phase       = r_phase;
    assign synced      = r_synced;
    assign tick_cnt    = r_tick_cnt;
    assign cycle_cnt   = r_cycle_cnt;
    assign err_illegal = r_err_illegal;
    assign err_order   = r_err_order;
    assign err_time    = r_err_time;

endmodule
